ring_renderer: RTL and testbench

Pixel-rendering stage directly downstream of the VGA timing generator. Consumes the generator's sync and blank strobes plus a pixel-enable, reconstructs the active-area pixel coordinates, and draws an animated ring centred on the screen with an optional border. Outputs 1-bit-per-channel RGB and delay-matched sync signals to the DAC pins. The squared-distance datapath is pipelined so it closes timing at the system clock.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/radius_fsm.sv | 62 ++++++
 rtl/ring_renderer.sv | 130 +++++++++++++
 tb/tb_ring_renderer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, colour encodings, radius FSM states and the
// sideband word that travels alongside the ring datapath.
package vga_pkg;

  localparam int H_ACT_PX = 640;
  localparam int V_ACT_LN = 480;
  localparam int H_SYNC_W = 96;
  localparam int V_SYNC_W = 2;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;

  typedef enum logic {GROW, SHRINK} rad_state_t;

  // blank/border/syncs delayed in step with the squared-distance pipeline
  typedef struct packed {
    logic blank;
    logic border;
    logic hs;
    logic vs;
  } side_t;

  localparam side_t SIDE_RST = '{blank: 1'b1, border: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/radius_fsm.sv
// Ring radius animation: bounces r between R_MIN and R_MAX one step per
// frame, latches r*r one strobe after the frame boundary, flags each frame.
module radius_fsm
  import vga_pkg::*;
#(
  parameter int R_MIN  = 40,
  parameter int R_MAX  = 200,
  parameter int R_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        boundary,
  input  logic        animate,
  output logic [15:0] r2,
  output logic        frame
);

  localparam logic [7:0] RMIN  = 8'(R_MIN);
  localparam logic [7:0] RMAX  = 8'(R_MAX);
  localparam logic [7:0] RSTEP = 8'(R_STEP);

  rad_state_t state;
  logic [7:0] r;
  logic       load;

  // radius update at the boundary, r*r latched on the following strobe so it
  // always sees the new radius and stays fixed for the whole frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r     <= RMIN;
      state <= GROW;
      r2    <= 16'(R_MIN * R_MIN);
      load  <= 1'b0;
      frame <= 1'b0;
    end else begin
      frame <= pix_en && boundary;
      if (pix_en) begin
        load <= boundary;
        if (load) r2 <= 16'(r) * 16'(r);
        if (boundary && animate) begin
          if (state == GROW) begin
            if ({1'b0, r} + {1'b0, RSTEP} >= {1'b0, RMAX}) begin
              r     <= RMAX;
              state <= SHRINK;
            end else begin
              r <= r + RSTEP;
            end
          end else begin
            if ({1'b0, r} <= {1'b0, RMIN} + {1'b0, RSTEP}) begin
              r     <= RMIN;
              state <= GROW;
            end else begin
              r <= r - RSTEP;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/ring_renderer.sv
// Pixel stage after the VGA timing generator: rebuilds x/y from the blank
// strobes, draws a centred animated ring plus optional red border, and
// delays the syncs to stay aligned with the 4-stage colour pipeline.
module ring_renderer
  import vga_pkg::*;
#(
  parameter int H_ACT  = vga_pkg::H_ACT_PX,
  parameter int V_ACT  = vga_pkg::V_ACT_LN,
  parameter int CX     = 320,
  parameter int CY     = 240,
  parameter int R_MIN  = 40,
  parameter int R_MAX  = 200,
  parameter int R_STEP = 1,
  parameter int BAND   = 400
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pix_en,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_hblank,
  input  logic       i_vblank,
  input  logic [1:0] i_sel,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_red,
  output logic       o_grn,
  output logic       o_blu,
  output logic       o_frame
);

  logic [10:0] x, y;
  logic        hblank_d, vblank_d, armed;
  logic        boundary;
  logic [15:0] r2;
  logic [22:0] r2w, hi, lo, sum;

  logic signed [11:0] dx, dy;
  logic signed [21:0] dxe, dye;
  logic        [21:0] dx2, dy2;
  logic               hit;
  side_t              side_in;
  side_t [2:0]        side_pipe;

  // vblank_d resets high so a reset inside vblank does not fake a boundary
  assign boundary = i_vblank && !vblank_d;

  // armed stays low after reset until vblank is seen, so a mid-frame release
  // renders black instead of a ring at bogus coordinates
  assign side_in = '{blank:  i_hblank || i_vblank || !armed,
                     border: i_sel[1] && (x == 11'd0 || x == 11'(H_ACT - 1) ||
                                          y == 11'd0 || y == 11'(V_ACT - 1)),
                     hs:     i_hsync,
                     vs:     i_vsync};

  assign r2w = 23'(r2);
  assign hi  = r2w + 23'(BAND);
  assign lo  = (r2w < 23'(BAND)) ? '0 : r2w - 23'(BAND);
  assign dxe = {{10{dx[11]}}, dx};
  assign dye = {{10{dy[11]}}, dy};
  assign sum = 23'(dx2) + 23'(dy2);

  // coordinate reconstruction from the blank strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x        <= '0;
      y        <= '0;
      hblank_d <= 1'b1;
      vblank_d <= 1'b1;
      armed    <= 1'b0;
    end else if (i_pix_en) begin
      hblank_d <= i_hblank;
      vblank_d <= i_vblank;
      armed    <= armed || i_vblank;
      x        <= i_hblank ? 11'd0 : x + 11'd1;
      if (i_vblank)                   y <= '0;
      else if (i_hblank && !hblank_d) y <= y + 11'd1;
    end
  end

  // S1 offsets, S2 squares, S3 window compare; sideband shifts in lockstep
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dx        <= '0;
      dy        <= '0;
      dx2       <= '0;
      dy2       <= '0;
      hit       <= 1'b0;
      side_pipe <= {3{SIDE_RST}};
    end else if (i_pix_en) begin
      dx        <= 12'(x) - 12'(CX);
      dy        <= 12'(y) - 12'(CY);
      dx2       <= 22'(dxe * dxe);
      dy2       <= 22'(dye * dye);
      hit       <= (sum > lo) && (sum < hi);
      side_pipe <= {side_pipe[1:0], side_in};
    end
  end

  // output register: blank beats ring beats border
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hsync                <= 1'b1;
      o_vsync                <= 1'b1;
      {o_red, o_grn, o_blu} <= BLACK;
    end else if (i_pix_en) begin
      o_hsync <= side_pipe[2].hs;
      o_vsync <= side_pipe[2].vs;
      if (side_pipe[2].blank)       {o_red, o_grn, o_blu} <= BLACK;
      else if (hit)                 {o_red, o_grn, o_blu} <= WHITE;
      else if (side_pipe[2].border) {o_red, o_grn, o_blu} <= RED;
      else                          {o_red, o_grn, o_blu} <= BLACK;
    end
  end

  radius_fsm #(
    .R_MIN (R_MIN),
    .R_MAX (R_MAX),
    .R_STEP(R_STEP)
  ) u_rad (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .pix_en  (i_pix_en),
    .boundary(boundary),
    .animate (i_sel[0]),
    .r2      (r2),
    .frame   (o_frame)
  );

endmodule

// File: tb/tb_ring_renderer.sv
// Directed bench: three renderers (R_MIN 40 / 100 / 10) share one shortened
// pixel stream; only lines y = 0, 240, 479 are full width.
module tb_ring_renderer;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst_n, pix_en, hs, vs, hb, vb;
  logic [1:0] sel;
  logic hs_a, vs_a, ra, ga, ba, fa;
  logic hs_s, vs_s, rs, gs, bs, fs;
  logic hs_z, vs_z, rz, gz, bz, fz;

  int checks = 0;
  int errors = 0;
  int ns = 0;
  int nf_a, nf_s, nf_z;
  int bv, b0, b240, b479;

  logic [2:0] l_a [0:8191];
  logic [2:0] l_s [0:8191];
  logic [2:0] l_z [0:8191];
  logic       l_hs[0:8191];

  always #5 clk = ~clk;

  ring_renderer dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_hsync(hs), .i_vsync(vs),
    .i_hblank(hb), .i_vblank(vb), .i_sel(sel), .o_hsync(hs_a), .o_vsync(vs_a),
    .o_red(ra), .o_grn(ga), .o_blu(ba), .o_frame(fa));

  ring_renderer #(.R_MIN(100)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_hsync(hs), .i_vsync(vs),
    .i_hblank(hb), .i_vblank(vb), .i_sel(sel), .o_hsync(hs_s), .o_vsync(vs_s),
    .o_red(rs), .o_grn(gs), .o_blu(bs), .o_frame(fs));

  ring_renderer #(.R_MIN(10)) dut_z (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_hsync(hs), .i_vsync(vs),
    .i_hblank(hb), .i_vblank(vb), .i_sel(sel), .o_hsync(hs_z), .o_vsync(vs_z),
    .o_red(rz), .o_grn(gz), .o_blu(bz), .o_frame(fz));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one pixel strobe followed by one idle cycle; outputs logged per strobe
  task automatic strobe(input logic hb_i, input logic vb_i, input logic hs_i, input logic vs_i);
    hb = hb_i; vb = vb_i; hs = hs_i; vs = vs_i; pix_en = 1'b1;
    @(posedge clk); #1;
    l_a[ns % 8192] = {ra, ga, ba};
    l_s[ns % 8192] = {rs, gs, bs};
    l_z[ns % 8192] = {rz, gz, bz};
    l_hs[ns % 8192] = hs_s;
    nf_a += int'(fa); nf_s += int'(fs); nf_z += int'(fz);
    pix_en = 1'b0;
    @(posedge clk); #1;
    nf_a += int'(fa); nf_s += int'(fs); nf_z += int'(fz);
    ns++;
  endtask

  task automatic line(input int len, output int base);
    base = ns;
    for (int i = 0; i < len; i++) strobe(1'b0, 1'b0, 1'b1, 1'b1);
    strobe(1'b1, 1'b0, 1'b1, 1'b1);
    strobe(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic vblank_ph(input int n);
    for (int i = 0; i < n; i++) strobe(1'b1, 1'b1, 1'b1, (i == 1 || i == 2) ? 1'b0 : 1'b1);
  endtask

  task automatic frame(input logic [1:0] sel_mid);
    int b;
    bv = ns;
    vblank_ph(4);
    for (int yy = 0; yy < 480; yy++) begin
      if (yy == 300) sel = sel_mid;
      line((yy == 0 || yy == 240 || yy == 479) ? 640 : 1, b);
      if (yy == 0)   b0 = b;
      if (yy == 240) b240 = b;
      if (yy == 479) b479 = b;
    end
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  // pixel strobed at index base+x shows on the output after strobe base+x+3
  function automatic logic [31:0] pa(input int base, input int x);
    return 32'(l_a[(base + x + 3) % 8192]);
  endfunction
  function automatic logic [31:0] ps(input int base, input int x);
    return 32'(l_s[(base + x + 3) % 8192]);
  endfunction
  function automatic logic [31:0] pz(input int base, input int x);
    return 32'(l_z[(base + x + 3) % 8192]);
  endfunction

  initial begin
    int b;
    rst_n = 1'b1; pix_en = 1'b0; hs = 1'b1; vs = 1'b1; hb = 1'b1; vb = 1'b1; sel = 2'b00;
    nf_a = 0; nf_s = 0; nf_z = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_hs_a", 32'(hs_a), 1); chk("rst_vs_a", 32'(vs_a), 1);
    chk("rst_hs_s", 32'(hs_s), 1); chk("rst_vs_z", 32'(vs_z), 1);
    chk("rst_rgb_a", 32'({ra, ga, ba}), 0); chk("rst_frame", 32'(fa), 0);
    chk("rst_r", 32'(dut_a.u_rad.r), 40); chk("rst_state", 32'(dut_a.u_rad.state), 32'(GROW));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // frame A: static, no border
    sel = 2'b00;
    frame(2'b00);
    chk("a_360_240", pa(b240, 360), 3'b111);
    chk("a_320_240", pa(b240, 320), 3'b000);
    chk("a_0_240_noborder", pa(b240, 0), 3'b000);
    chk("s_420_240", ps(b240, 420), 3'b111);
    chk("s_320_240", ps(b240, 320), 3'b000);
    chk("s_418_240", ps(b240, 418), 3'b111);
    chk("s_417_240", ps(b240, 417), 3'b000);
    chk("s_320_0", ps(b0, 320), 3'b000);
    chk("z_320_240_sat", pz(b240, 320), 3'b000);
    chk("z_330_240", pz(b240, 330), 3'b111);
    chk("lat_hs_pre", 32'(l_hs[(b240 + 643) % 8192]), 1);
    chk("lat_hs_edge", 32'(l_hs[(b240 + 644) % 8192]), 0);
    chk("lat_hs_post", 32'(l_hs[(b240 + 645) % 8192]), 1);

    // partial frame, hold between strobes, then asynchronous reset mid-line
    vblank_ph(4);
    for (int i = 0; i < 240; i++) line(1, b);
    for (int i = 0; i <= 421; i++) strobe(1'b0, 1'b0, 1'b1, 1'b1);
    chk("pre_hold_s", 32'({rs, gs, bs}), 3'b111);
    hb = 1'b1; vb = 1'b1; hs = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("hold_s", 32'({rs, gs, bs}), 3'b111);
    hb = 1'b0; vb = 1'b0; hs = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_rgb_s", 32'({rs, gs, bs}), 3'b000);
    chk("midrst_hs_s", 32'(hs_s), 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // after release without a vblank: ring position still renders black
    for (int i = 0; i < 240; i++) line(1, b);
    line(640, b);
    chk("unarmed_420", ps(b, 420), 3'b000);
    chk("unarmed_418", ps(b, 418), 3'b000);

    // frame B: border on
    sel = 2'b10;
    nf_a = 0; nf_s = 0; nf_z = 0;
    frame(2'b10);
    chk("brd_0_240", ps(b240, 0), 3'b100);
    chk("brd_639_240", ps(b240, 639), 3'b100);
    chk("brd_320_0", ps(b0, 320), 3'b100);
    chk("brd_320_479", ps(b479, 320), 3'b100);
    chk("brd_0_0", ps(b0, 0), 3'b100);
    chk("brd_ring_420", ps(b240, 420), 3'b111);
    chk("brd_inner_100", ps(b240, 100), 3'b000);
    chk("brd_hblank", ps(b0, 640), 3'b000);
    chk("brd_vblank", ps(bv, 0), 3'b000);
    chk("brd_a_360", pa(b240, 360), 3'b111);
    chk("frame_pulse_b", 32'(nf_a), 1);

    // animation: 160 boundaries take r from 40 to 200
    sel = 2'b01;
    nf_a = 0; nf_s = 0; nf_z = 0;
    for (int f = 0; f < 160; f++) begin
      vblank_ph(2);
      strobe(1'b0, 1'b0, 1'b1, 1'b1);
    end
    chk("anim_pulses_a", 32'(nf_a), 160);
    chk("anim_pulses_s", 32'(nf_s), 160);
    chk("anim_pulses_z", 32'(nf_z), 160);
    chk("anim_r200", 32'(dut_a.u_rad.r), 200);
    chk("anim_shrink", 32'(dut_a.u_rad.state), 32'(SHRINK));

    // frame C: hold r=200; enabling animation mid-frame waits for the boundary
    sel = 2'b00;
    frame(2'b01);
    chk("c_520_240", pa(b240, 520), 3'b111);
    chk("c_420_240", pa(b240, 420), 3'b000);
    chk("c_r_held", 32'(dut_a.u_rad.r), 200);
    vblank_ph(2);
    strobe(1'b0, 1'b0, 1'b1, 1'b1);
    chk("anim_r199", 32'(dut_a.u_rad.r), 199);
    chk("anim_still_shrink", 32'(dut_a.u_rad.state), 32'(SHRINK));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
